// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_arbiter
//  Description : Round-robin arbiter sharing one spi_master between N_REQ
//                requesters. Serialises commands onto the master's
//                data_in/start port, waits for done, returns read data and a
//                one-cycle acknowledge to the granted requester.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CMD_W      = 10,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 3
) (
    input  logic                   i_spi_arb_clk,
    input  logic                   i_spi_arb_rst,
    input  logic [N_REQ-1:0]       i_spi_arb_req,
    input  logic [N_REQ*CMD_W-1:0] i_spi_arb_cmd,
    output logic [N_REQ-1:0]       o_spi_arb_gnt,
    output logic [N_REQ-1:0]       o_spi_arb_ack,
    output logic [DATA_W-1:0]      o_spi_arb_rdata,
    output logic                   o_spi_arb_busy,
    output logic [CMD_W-1:0]       o_spi_arb_m_data_in,
    output logic                   o_spi_arb_m_start,
    input  logic                   i_spi_arb_m_done,
    input  logic [DATA_W-1:0]      i_spi_arb_m_data_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_one      = N_REQ'(1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       c_rd_op    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [IDX_W-1:0]    r_last;
    logic [CMD_W-1:0]    r_cmd;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_m_start;
    logic [GAP_W-1:0]    r_gap_cnt;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W-1:0]    w_idx;
    logic [CMD_W-1:0]    w_win_cmd;
    logic                w_is_read;

    // Round-robin search: scan from last+1 upward (wrapping), first set req wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(r_last) + i) % N_REQ);
            if (!w_found && i_spi_arb_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_win_cmd = i_spi_arb_cmd[int'(w_winner)*CMD_W +: CMD_W];
    assign w_is_read = (r_cmd[CMD_W-1 -: 2] == c_rd_op);

    // State register.
    always_ff @(posedge i_spi_arb_clk or posedge i_spi_arb_rst) begin
        if (i_spi_arb_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_found) w_state_next = S_GRANT;
            S_GRANT:     w_state_next = S_START;
            S_START:     w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (i_spi_arb_m_done) w_state_next = S_RESP;
            S_RESP:      w_state_next = S_GAP;
            S_GAP:       if (r_gap_cnt == c_gap_last) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Gap counter: number of cycles already spent in GAP.
    always_ff @(posedge i_spi_arb_clk or posedge i_spi_arb_rst) begin
        if (i_spi_arb_rst) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Registered outputs. The winner's command, grant and last pointer are
    // captured on the IDLE->GRANT edge so they are already visible while in
    // GRANT (one cycle after the request is sampled).
    always_ff @(posedge i_spi_arb_clk or posedge i_spi_arb_rst) begin
        if (i_spi_arb_rst) begin
            r_last    <= c_last_rst;
            r_cmd     <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_m_start <= 1'b0;
        end else begin
            r_busy    <= (w_state_next != S_IDLE);
            r_m_start <= (r_state == S_GRANT);
            r_ack     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_cmd  <= w_win_cmd;
                        r_gnt  <= c_one << w_winner;
                        r_last <= w_winner;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_spi_arb_m_done) begin
                        r_ack   <= r_gnt;
                        r_rdata <= w_is_read ? i_spi_arb_m_data_out : '0;
                    end
                end
                S_RESP: begin
                    r_gnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_spi_arb_gnt       = r_gnt;
    assign o_spi_arb_ack       = r_ack;
    assign o_spi_arb_rdata     = r_rdata;
    assign o_spi_arb_busy      = r_busy;
    assign o_spi_arb_m_data_in = r_cmd;
    assign o_spi_arb_m_start   = r_m_start;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_arbiter
//  Description : Self-checking bench for spi_arbiter: table of directed
//                transactions plus hand-written multi-cycle corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_arbiter;

    localparam int N   = 4;
    localparam int CW  = 10;
    localparam int DW  = 8;
    localparam int GAP = 3;

    logic            r_clk = 1'b0;
    logic            r_rst = 1'b1;
    logic [N-1:0]    r_req = '0;
    logic [N*CW-1:0] r_cmd = '0;
    logic            r_mdl_done = 1'b0;
    logic [DW-1:0]   r_mdl_dout = 8'hEE;
    logic            r_man_done = 1'b0;
    logic [DW-1:0]   r_man_dout = 8'h00;
    logic            r_model_en = 1'b1;
    logic [DW-1:0]   r_model_dout = 8'h00;

    logic [N-1:0]    w_gnt;
    logic [N-1:0]    w_ack;
    logic [DW-1:0]   w_rdata;
    logic            w_busy;
    logic [CW-1:0]   w_m_data_in;
    logic            w_m_start;
    logic            w_m_done;
    logic [DW-1:0]   w_m_data_out;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    assign w_m_done     = r_mdl_done | r_man_done;
    assign w_m_data_out = r_man_done ? r_man_dout : r_mdl_dout;

    spi_arbiter #(.N_REQ(N), .CMD_W(CW), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
        .i_spi_arb_clk        (r_clk),
        .i_spi_arb_rst        (r_rst),
        .i_spi_arb_req        (r_req),
        .i_spi_arb_cmd        (r_cmd),
        .o_spi_arb_gnt        (w_gnt),
        .o_spi_arb_ack        (w_ack),
        .o_spi_arb_rdata      (w_rdata),
        .o_spi_arb_busy       (w_busy),
        .o_spi_arb_m_data_in  (w_m_data_in),
        .o_spi_arb_m_start    (w_m_start),
        .i_spi_arb_m_done     (w_m_done),
        .i_spi_arb_m_data_out (w_m_data_out)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // SPI master model: done pulse with data two cycles after start is seen.
    initial begin
        forever begin
            tick();
            if (w_m_start && r_model_en) begin
                repeat (2) tick();
                r_mdl_done = 1'b1;
                r_mdl_dout = r_model_dout;
                tick();
                r_mdl_done = 1'b0;
                r_mdl_dout = 8'hEE;
            end
        end
    end

    // Protocol monitor: one-hot grant/ack, single-cycle pulses, start spacing.
    initial begin
        int  last_ack = -1000;
        logic prev_start = 1'b0;
        logic prev_ack   = 1'b0;
        forever begin
            tick();
            cyc++;
            chk("mon_gnt_onehot0", 40'($onehot0(w_gnt)), 40'(1));
            chk("mon_ack_onehot0", 40'($onehot0(w_ack)), 40'(1));
            if (w_m_start && prev_start) chk("mon_start_width", 40'(1), 40'(0));
            if ((w_ack != 0) && prev_ack) chk("mon_ack_width", 40'(1), 40'(0));
            if (w_m_start && !prev_start)
                chk("mon_ack_to_start", 40'((cyc - last_ack) >= GAP + 3), 40'(1));
            if (w_ack != 0) last_ack = cyc;
            prev_start = w_m_start;
            prev_ack   = (w_ack != 0);
        end
    end

    // One full transaction with the model answering; returns grant latency.
    task automatic txn(input string nm, input int idx, input logic [CW-1:0] ecmd,
                       input logic [DW-1:0] erd, output int lat);
        int n;
        logic stable;
        logic [N-1:0] oh;
        oh = 4'b0001 << idx;
        n  = 0;
        while (w_gnt == 0 && n < 50) begin tick(); n++; end
        lat = n;
        chk({nm, " gnt_timeout"}, 40'(n < 50), 40'(1));
        chk({nm, " gnt"}, 40'(w_gnt), 40'(oh));
        chk({nm, " data_in"}, 40'(w_m_data_in), 40'(ecmd));
        chk({nm, " busy"}, 40'(w_busy), 40'(1));
        tick();
        chk({nm, " start"}, 40'(w_m_start), 40'(1));
        stable = 1'b1;
        n = 0;
        while (w_ack == 0 && n < 50) begin
            tick();
            n++;
            if (w_m_data_in != ecmd || w_gnt != oh) stable = 1'b0;
        end
        chk({nm, " ack_timeout"}, 40'(n < 50), 40'(1));
        chk({nm, " held"}, 40'(stable), 40'(1));
        chk({nm, " ack"}, 40'(w_ack), 40'(oh));
        chk({nm, " rdata"}, 40'(w_rdata), 40'(erd));
        tick();
        chk({nm, " ack_drop"}, 40'(w_ack), 40'(0));
        chk({nm, " gnt_drop"}, 40'(w_gnt), 40'(0));
    endtask

    typedef struct {
        logic [N-1:0]    req;
        logic [N*CW-1:0] cmd;
        logic [DW-1:0]   dout;
        int              exp_idx;
        logic [CW-1:0]   exp_cmd;
        logic [DW-1:0]   exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat;
        int n;
        logic quiet;
        logic [N*CW-1:0] c_cont;
        c_cont = {10'h044, 10'h333, 10'h122, 10'h311};
        vecs[0] = '{4'b1111, c_cont, 8'h5A, 0, 10'h311, 8'h5A};
        vecs[1] = '{4'b1111, c_cont, 8'h6B, 1, 10'h122, 8'h00};
        vecs[2] = '{4'b1111, c_cont, 8'h7C, 2, 10'h333, 8'h7C};
        vecs[3] = '{4'b1111, c_cont, 8'h8D, 3, 10'h044, 8'h00};
        vecs[4] = '{4'b1111, c_cont, 8'h9E, 0, 10'h311, 8'h9E};
        vecs[5] = '{4'b0100, {10'h044, 10'h155, 10'h122, 10'h311}, 8'h77, 2, 10'h155, 8'h00};
        vecs[6] = '{4'b0010, {10'h044, 10'h155, 10'h3A5, 10'h311}, 8'hC3, 1, 10'h3A5, 8'hC3};
        vecs[7] = '{4'b1001, {10'h2F0, 10'h155, 10'h3A5, 10'h3C3}, 8'hA1, 3, 10'h2F0, 8'h00};
        vecs[8] = '{4'b1001, {10'h2F0, 10'h155, 10'h3A5, 10'h3C3}, 8'hB2, 0, 10'h3C3, 8'hB2};

        // Reset state, with all requesters already asking.
        r_req = 4'b1111;
        r_cmd = c_cont;
        repeat (3) tick();
        chk("rst gnt", 40'(w_gnt), 40'(0));
        chk("rst ack", 40'(w_ack), 40'(0));
        chk("rst rdata", 40'(w_rdata), 40'(0));
        chk("rst busy", 40'(w_busy), 40'(0));
        chk("rst start", 40'(w_m_start), 40'(0));
        chk("rst data_in", 40'(w_m_data_in), 40'(0));
        r_rst = 1'b0;

        // Table: contention 0,1,2,3,0; single write; single read; fairness.
        for (int i = 0; i < 9; i++) begin
            r_req        = vecs[i].req;
            r_cmd        = vecs[i].cmd;
            r_model_dout = vecs[i].dout;
            txn($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_cmd, vecs[i].exp_rd, lat);
            if (i == 0) chk("vec0 latency", 40'(lat), 40'(1));
        end
        r_req = '0;

        // Cmd change and req drop during WAIT_DONE; done outside WAIT_DONE.
        r_model_en = 1'b0;
        r_cmd = {10'h044, 10'h155, 10'h3A5, 10'h3AA};
        r_req = 4'b0001;
        n = 0;
        while (!w_m_start && n < 50) begin tick(); n++; end
        chk("chg start_timeout", 40'(n < 50), 40'(1));
        tick();
        r_cmd = {10'h044, 10'h155, 10'h3A5, 10'h000};
        r_req = 4'b0000;
        repeat (4) tick();
        chk("chg data_in", 40'(w_m_data_in), 40'(10'h3AA));
        chk("chg gnt", 40'(w_gnt), 40'(4'b0001));
        chk("chg no_early_ack", 40'(w_ack), 40'(0));
        r_man_done = 1'b1;
        r_man_dout = 8'h42;
        tick();
        r_man_done = 1'b0;
        chk("chg ack", 40'(w_ack), 40'(4'b0001));
        chk("chg rdata", 40'(w_rdata), 40'(8'h42));
        tick();
        r_man_done = 1'b1;
        tick();
        r_man_done = 1'b0;
        quiet = 1'b1;
        repeat (6) begin tick(); if (w_ack != 0) quiet = 1'b0; end
        chk("stray_done no_ack", 40'(quiet), 40'(1));
        chk("stray_done idle", 40'(w_busy), 40'(0));

        // Reset while waiting for done; then 1001 must go to requester 0.
        r_cmd = {10'h044, 10'h3FF, 10'h3A5, 10'h000};
        r_req = 4'b0100;
        n = 0;
        while (!w_m_start && n < 50) begin tick(); n++; end
        chk("rstw start_timeout", 40'(n < 50), 40'(1));
        tick();
        r_rst = 1'b1;
        tick();
        chk("rstw gnt", 40'(w_gnt), 40'(0));
        chk("rstw ack", 40'(w_ack), 40'(0));
        chk("rstw busy", 40'(w_busy), 40'(0));
        chk("rstw start", 40'(w_m_start), 40'(0));
        chk("rstw data_in", 40'(w_m_data_in), 40'(0));
        chk("rstw rdata", 40'(w_rdata), 40'(0));
        r_rst = 1'b0;
        r_req = '0;
        r_man_done = 1'b1;
        r_man_dout = 8'h99;
        tick();
        r_man_done = 1'b0;
        quiet = 1'b1;
        repeat (4) begin tick(); if (w_ack != 0 || w_busy) quiet = 1'b0; end
        chk("rstw quiet", 40'(quiet), 40'(1));
        r_model_en   = 1'b1;
        r_model_dout = 8'h55;
        r_cmd = {10'h111, 10'h3FF, 10'h3A5, 10'h0AB};
        r_req = 4'b1001;
        txn("post_rst", 0, 10'h0AB, 8'h00, lat);
        r_req = '0;
        chk("post_rst latency", 40'(lat), 40'(1));

        repeat (8) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter that shares one `spi_master` between `N_REQ` independent requesters. It accepts per-requester command requests and serialises them onto the master's `data_in`/`start` interface. It waits for the master's `done`, then returns read data and a one-cycle acknowledge to the granted requester. It sits between the user-side clients (register blocks, sensor pollers) and the single SPI master instance.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `CMD_W`, 10, command width; bits [9:8]=2'b11 denote a read
- `DATA_W`, 8, read-data width
- `GAP_CYCLES`, 3, minimum cycles `o_spi_arb_m_start` stays low between transactions (must be ≥2, the master's start edge-detector depth)

Ports:
- `i_spi_arb_clk`  in  1  single clock, shared with spi_master
- `i_spi_arb_rst`  in  1  reset, asynchronous, active-high
- `i_spi_arb_req`  in  N_REQ  per-requester request level
- `i_spi_arb_cmd`  in  N_REQ*CMD_W  flattened commands; requester k at [k*CMD_W +: CMD_W]
- `o_spi_arb_gnt`  out  N_REQ  one-hot grant, high from GRANT through RESP
- `o_spi_arb_ack`  out  N_REQ  one-hot, one-cycle completion pulse
- `o_spi_arb_rdata`  out  DATA_W  read data, valid while ack is high
- `o_spi_arb_busy`  out  1  high whenever state ≠ IDLE
- `o_spi_arb_m_data_in`  out  CMD_W  to master `data_in`, held stable for whole transaction
- `o_spi_arb_m_start`  out  1  to master `start`
- `i_spi_arb_m_done`  in  1  master done pulse
- `i_spi_arb_m_data_out`  in  DATA_W  master read data

## Operation
- States: IDLE, GRANT, START, WAIT_DONE, RESP, GAP.
- IDLE: if any req is high, select the winner round-robin: search begins at `last+1` modulo N_REQ, and the first set bit wins. Go to GRANT. Otherwise stay in IDLE.
- GRANT: latch the winner's cmd into the internal `cmd_reg`. Drive `m_data_in` = `cmd_reg`. Set `gnt[winner]`. Update `last` = winner. Go to START.
- START: `m_start` = 1 for exactly one cycle. Go to WAIT_DONE.
- WAIT_DONE: hold `m_data_in` and `gnt`. When `m_done` = 1, capture rdata and go to RESP.
  - Read (`cmd_reg[9:8]` = 2'b11): rdata ← `m_data_out`.
  - Otherwise: rdata ← 0.
- RESP: `ack[winner]` = 1 for one cycle. Go to GAP. `gnt` drops on exit.
- GAP: count `GAP_CYCLES` cycles with `m_start` low, then go to IDLE.
- `m_data_in` holds `cmd_reg` in every state; it is never driven from a live requester input.
- The requester must hold req until ack and drop it on the cycle after ack. A req still high when IDLE is re-entered is treated as a new request.
- Dropping req while granted does not abort the transaction; the ack is still issued.
- Changes to `i_spi_arb_cmd` after GRANT are ignored.
- There is no timeout: if the master never returns done, the arbiter stays in WAIT_DONE until reset.

## Timing
- Reset values:
  - `gnt` = 0, `ack` = 0, `rdata` = 0, `busy` = 0, `m_start` = 0, `m_data_in` = 0.
  - State = IDLE.
  - `last` = N_REQ-1, so requester 0 wins first after reset.
- All outputs are registered.
- Latency from req sampled high in IDLE at cycle T:
  - T+1: `gnt` and `m_data_in` valid.
  - T+2: `m_start` high.
  - ack is high on the cycle after `m_done` is sampled.
- Back-to-back throughput: ack → next `m_start` ≥ GAP_CYCLES+3 cycles.
- Simultaneous requests: exactly one grant; the others wait for the next IDLE. A new req arriving mid-transaction waits for the next IDLE.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values; no ack is issued. The system resets spi_master in the same event.
- `m_done` outside WAIT_DONE is ignored.

## Test plan
- Single write: req[2]=1, cmd=10'h155 → gnt=4'b0100 at T+1, `m_data_in`=10'h155, one `m_start` pulse at T+2; after the model's done, ack=4'b0100 for 1 cycle, rdata=0.
- Single read: req[1], cmd=10'h3A5, model returns 8'hC3 with done → ack[1] pulse with rdata=8'hC3, then ≥GAP_CYCLES low cycles on `m_start`.
- Contention: req=4'b1111 held continuously from reset → grant order 0,1,2,3,0; one-hot gnt; no overlap between transactions.
- Fairness after skip: last=1, req=4'b1001 → grant 3, then 0.
- Cmd change during WAIT_DONE: requester changes cmd to 10'h000 → `m_data_in` stays at the original value; requester drops req → ack still issued.
- Reset in WAIT_DONE → outputs at reset values next edge, no ack; next req[0] is served normally.
